rx_ctrl: RTL and testbench

UART receive sequencer for the `rx_dp` capture datapath. It synchronises the serial line, detects and validates the start bit, and times each bit from a baud counter. It drives `rx_en` and the bit index `bit_cnto` so the datapath captures bits 0..7 and presents the assembled byte. At the stop bit it reports either a byte-done pulse or a framing error. It sits between the raw `rx` pin and `rx_dp` inside the UART top.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 22 ++
 rtl/rx_ctrl.sv | 126 ++++++++++++
 tb/tb_rx_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-sequencer state encoding, bit-index
// constants and the default bit period.
package uart_pkg;

    localparam int unsigned BIT_CNT_W       = 10;
    localparam int unsigned CLK_DIV_DEFAULT = 434;

    localparam logic [BIT_CNT_W-1:0] BCNT_START   = 10'd0;
    localparam logic [BIT_CNT_W-1:0] BCNT_PRESENT = 10'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous serial lines; both flops reset
// to 1 so an idle (high) line is seen during and right after reset.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_ctrl.sv
// UART receive sequencer: start-bit detection/validation, mid-bit timing
// and bit-index sequencing for the rx_dp capture datapath.
module rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic                 rx_en,
    output logic [BIT_CNT_W-1:0] bit_cnto,
    output logic                 rx_sync,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);

    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic                 rx_en_n, rx_done_n, frame_err_n;
    logic [BIT_CNT_W-1:0] bit_cnto_n;
    logic                 rx_prev;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_sync)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            rx_en     <= 1'b0;
            bit_cnto  <= BCNT_START;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_prev   <= 1'b1;
        end else begin
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            bit_idx   <= bit_idx_n;
            rx_en     <= rx_en_n;
            bit_cnto  <= bit_cnto_n;
            rx_done   <= rx_done_n;
            frame_err <= frame_err_n;
            rx_prev   <= rx_sync;
        end
    end

    always_comb begin
        state_n     = state;
        clk_cnt_n   = clk_cnt + 1'b1;
        bit_idx_n   = bit_idx;
        rx_en_n     = rx_en;
        bit_cnto_n  = bit_cnto;
        rx_done_n   = 1'b0;
        frame_err_n = 1'b0;

        case (state)
            ST_IDLE: begin
                rx_en_n    = 1'b0;
                bit_cnto_n = BCNT_START;
                clk_cnt_n  = '0;
                bit_idx_n  = '0;
                if (rx_prev && !rx_sync)
                    state_n = ST_START;
            end
            ST_START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_n = '0;
                    if (!rx_sync) begin
                        rx_en_n    = 1'b1;
                        bit_cnto_n = BCNT_START;
                        state_n    = ST_DATA;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_n  = '0;
                    bit_cnto_n = BIT_CNT_W'(bit_idx) + 10'd1;
                    bit_idx_n  = bit_idx + 1'b1;
                    if (bit_idx == 3'd7)
                        state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                // rx_en stays high through the cycle that presents the byte
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_n  = '0;
                    bit_cnto_n = BCNT_PRESENT;
                    if (rx_sync) begin
                        rx_done_n = 1'b1;
                        state_n   = ST_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                rx_en_n   = 1'b0;
                clk_cnt_n = '0;
                if (rx_sync)
                    state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_rx_ctrl.sv
// Self-checking bench for rx_ctrl with CLK_DIV=16: table of frames plus
// hand-written glitch, back-to-back and mid-frame reset sequences.
module tb_rx_ctrl;

    localparam int unsigned DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_en;
    logic [9:0] bit_cnto;
    logic       rx_sync;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    rx_ctrl #(.CLK_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rx_en     (rx_en),
        .bit_cnto  (bit_cnto),
        .rx_sync   (rx_sync),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: tracks index steps, captures the byte the datapath would see,
    // and counts pulses and protocol anomalies.
    logic [9:0] prev_bc = '0;
    int         last_chg = 0;
    logic [7:0] cap = '0;
    logic [7:0] byte_out = '0;
    logic [7:0] last_byte = '0;
    logic [7:0] prev_byte = '0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, pulse_bc_bad = 0;
    int spacing_bad = 0, en_seen = 0, done_cyc = 0, prev_done_cyc = 0;

    always @(negedge clk) begin
        if (bit_cnto != prev_bc) begin
            if (bit_cnto >= 2 && bit_cnto <= 9)
                if (bit_cnto != prev_bc + 10'd1 || (cyc - last_chg) != DIV)
                    spacing_bad++;
            if (bit_cnto >= 1 && bit_cnto <= 8)
                cap[bit_cnto - 1] = rx_sync;
            if (bit_cnto == 9)
                byte_out = cap;
            last_chg = cyc;
            prev_bc  = bit_cnto;
        end
        if (rx_done) begin
            done_cnt++;
            prev_done_cyc = done_cyc;
            done_cyc      = cyc;
            prev_byte     = last_byte;
            last_byte     = byte_out;
        end
        if (frame_err) err_cnt++;
        if (rx_done && frame_err) both_cnt++;
        if ((rx_done || frame_err) && bit_cnto != 10'd9) pulse_bc_bad++;
        if (rx_en) en_seen++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic noise);
        rx_in = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            if (noise && !d[i]) begin
                tick(2);
                rx_in = 1'b1;
                tick(1);
                rx_in = 1'b0;
                tick(DIV - 3);
            end else begin
                tick(DIV);
            end
        end
        rx_in = stop;
        tick(DIV);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       noise;
        int         hold_low;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int d0, e0, en0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 0,  1, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 40, 0, 1};
        vecs[2] = '{8'h81, 1'b1, 1'b0, 0,  1, 0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 0,  1, 0};
        vecs[4] = '{8'h6B, 1'b1, 1'b1, 0,  1, 0};

        // reset state
        tick(3);
        chk("reset_rx_en", int'(rx_en), 0);
        chk("reset_bit_cnto", int'(bit_cnto), 0);
        chk("reset_rx_done", int'(rx_done), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_rx_busy", int'(rx_busy), 0);
        chk("reset_rx_sync", int'(rx_sync), 1);
        rst = 1'b1;
        tick(5);

        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].noise);
            if (vecs[v].hold_low > 0) begin
                tick(vecs[v].hold_low);
                chk("wait_idle_busy", int'(rx_busy), 1);
                chk("wait_idle_rx_en", int'(rx_en), 0);
                chk("wait_idle_no_frame", done_cnt + err_cnt - d0 - e0, 1);
                rx_in = 1'b1;
                tick(4);
                chk("wait_idle_release", int'(rx_busy), 0);
            end
            tick(20);
            chk("vec_done", done_cnt - d0, vecs[v].exp_done);
            chk("vec_err", err_cnt - e0, vecs[v].exp_err);
            chk("vec_byte", int'(byte_out), int'(vecs[v].data));
            chk("vec_idle", int'(rx_busy), 0);
        end

        // start glitch: four clocks low
        d0 = done_cnt; e0 = err_cnt; en0 = en_seen;
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        tick(3);
        chk("glitch_start_busy", int'(rx_busy), 1);
        tick(30);
        chk("glitch_rx_en", en_seen - en0, 0);
        chk("glitch_pulses", done_cnt + err_cnt - d0 - e0, 0);
        chk("glitch_idle", int'(rx_busy), 0);

        // back-to-back frames with a one-bit stop
        d0 = done_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        tick(20);
        chk("b2b_done", done_cnt - d0, 2);
        chk("b2b_gap", done_cyc - prev_done_cyc, 160);
        chk("b2b_byte0", int'(prev_byte), 8'h00);
        chk("b2b_byte1", int'(last_byte), 8'hFF);

        // asynchronous reset at bit index 4
        d0 = done_cnt; e0 = err_cnt;
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 200 && bit_cnto != 10'd4; i++) tick(1);
                chk("rst_reach_bc4", int'(bit_cnto), 4);
                #2 rst = 1'b0;
                #1;
                chk("rst_rx_en", int'(rx_en), 0);
                chk("rst_bit_cnto", int'(bit_cnto), 0);
                chk("rst_pulses", int'(rx_done) + int'(frame_err), 0);
                chk("rst_rx_busy", int'(rx_busy), 0);
                chk("rst_rx_sync", int'(rx_sync), 1);
                tick(3);
                rst = 1'b1;
            end
        join
        tick(20);
        chk("rst_abort_no_pulse", done_cnt + err_cnt - d0 - e0, 0);
        d0 = done_cnt;
        send_frame(8'h5A, 1'b1, 1'b0);
        tick(20);
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_byte", int'(byte_out), 8'h5A);

        // protocol invariants across the whole run
        chk("bit_spacing", spacing_bad, 0);
        chk("pulse_at_bc9", pulse_bc_bad, 0);
        chk("both_pulses", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
